// File: rtl/enc8x3.sv
// 8-to-3 priority encoder (bit 7 wins) with optional one-cycle output register.
// Define ENC8X3_MULTI_EN to add the multi output (two or more request bits set).
module enc8x3 #(
  parameter int REG_OUT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       valid
`ifdef ENC8X3_MULTI_EN
  ,
  output logic       multi
`endif
);

  logic [2:0] enc_out;
  logic       enc_valid;

  always_comb begin
    enc_out = 3'd0;
    casez (in)
      8'b1???????: enc_out = 3'd7;
      8'b01??????: enc_out = 3'd6;
      8'b001?????: enc_out = 3'd5;
      8'b0001????: enc_out = 3'd4;
      8'b00001???: enc_out = 3'd3;
      8'b000001??: enc_out = 3'd2;
      8'b0000001?: enc_out = 3'd1;
      default:     enc_out = 3'd0;
    endcase
    enc_valid = |in;
  end

`ifdef ENC8X3_MULTI_EN
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  logic enc_multi;
  assign enc_multi = |(in & (in - 8'd1));
`endif

  generate
    if (REG_OUT != 0) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out   <= 3'd0;
          valid <= 1'b0;
        end else if (en) begin
          out   <= enc_out;
          valid <= enc_valid;
        end
      end
`ifdef ENC8X3_MULTI_EN
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     multi <= 1'b0;
        else if (en) multi <= enc_multi;
      end
`endif
    end else begin : g_comb
      assign out   = enc_out;
      assign valid = enc_valid;
`ifdef ENC8X3_MULTI_EN
      assign multi = enc_multi;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_enc8x3.sv
// Directed bench for enc8x3: registered instance driven by a vector table plus
// reset/hold sequences, and a combinational instance swept over all 256 inputs.
module tb_enc8x3;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst;
  logic       en;
  logic [7:0] in;
  logic [2:0] out_r, out_c;
  logic       valid_r, valid_c;
  logic       multi_r, multi_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 if (clk_run) clk = ~clk;

  enc8x3 #(.REG_OUT(1)) u_reg (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out_r), .valid(valid_r)
`ifdef ENC8X3_MULTI_EN
    , .multi(multi_r)
`endif
  );

  enc8x3 #(.REG_OUT(0)) u_comb (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .out(out_c), .valid(valid_c)
`ifdef ENC8X3_MULTI_EN
    , .multi(multi_c)
`endif
  );

`ifndef ENC8X3_MULTI_EN
  assign multi_r = 1'b0;
  assign multi_c = 1'b0;
`endif

  typedef struct {
    logic [7:0] in;
    logic [2:0] out;
    logic       valid;
    logic       multi;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [2:0] a_out, input logic a_valid,
                       input logic a_multi, input logic [2:0] e_out, input logic e_valid,
                       input logic e_multi);
    n_cmp++;
`ifdef ENC8X3_MULTI_EN
    if ({a_out, a_valid, a_multi} !== {e_out, e_valid, e_multi}) begin
      n_bad++;
      $display("FAIL %s: got out=%b valid=%b multi=%b, want out=%b valid=%b multi=%b",
               name, a_out, a_valid, a_multi, e_out, e_valid, e_multi);
    end
`else
    if ({a_out, a_valid} !== {e_out, e_valid}) begin
      n_bad++;
      $display("FAIL %s: got out=%b valid=%b, want out=%b valid=%b (multi %b/%b unused)",
               name, a_out, a_valid, e_out, e_valid, a_multi, e_multi);
    end
`endif
  endtask

  // Capture one value on the next rising edge, then sample 1ns later.
  task automatic cycle(input logic e, input logic [7:0] v);
    @(negedge clk);
    en = e;
    in = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ref_out(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int b = 0; b < 8; b++) if (v[b]) r = 3'(b);
    return r;
  endfunction

  initial begin
    vecs[0]  = '{8'h00, 3'b000, 1'b0, 1'b0};
    vecs[1]  = '{8'h02, 3'b001, 1'b1, 1'b0};
    vecs[2]  = '{8'h07, 3'b010, 1'b1, 1'b1};
    vecs[3]  = '{8'h0A, 3'b011, 1'b1, 1'b1};
    vecs[4]  = '{8'h01, 3'b000, 1'b1, 1'b0};
    vecs[5]  = '{8'h0E, 3'b011, 1'b1, 1'b1};
    vecs[6]  = '{8'h1F, 3'b100, 1'b1, 1'b1};
    vecs[7]  = '{8'h40, 3'b110, 1'b1, 1'b0};
    vecs[8]  = '{8'h81, 3'b111, 1'b1, 1'b1};
    vecs[9]  = '{8'h10, 3'b100, 1'b1, 1'b0};
    vecs[10] = '{8'h00, 3'b000, 1'b0, 1'b0};

    // Reset state, and reset dominating en with a running clock.
    rst = 1'b1;
    en  = 1'b1;
    in  = 8'hFF;
    #1;
    check("reset_state", out_r, valid_r, multi_r, 3'b000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_holds_with_en", out_r, valid_r, multi_r, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Successive captures, each checked one cycle after capture.
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, vecs[i].in);
      check($sformatf("vec_%02h", vecs[i].in), out_r, valid_r, multi_r,
            vecs[i].out, vecs[i].valid, vecs[i].multi);
    end

    // Hold: load 0x40, then en low with a different in for three cycles.
    cycle(1'b1, 8'h40);
    check("hold_load_40", out_r, valid_r, multi_r, 3'b110, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 8'h03);
      check($sformatf("hold_cycle_%0d", k), out_r, valid_r, multi_r, 3'b110, 1'b1, 1'b0);
    end

    // Asynchronous reset mid-cycle while out = 111, then no stale value after release.
    cycle(1'b1, 8'hFF);
    check("pre_async_rst", out_r, valid_r, multi_r, 3'b111, 1'b1, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_immediate", out_r, valid_r, multi_r, 3'b000, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    cycle(1'b0, 8'hFF);
    check("no_stale_after_rst", out_r, valid_r, multi_r, 3'b000, 1'b0, 1'b0);
    cycle(1'b1, 8'h10);
    check("first_load_after_rst", out_r, valid_r, multi_r, 3'b100, 1'b1, 1'b0);

    // Combinational instance: full sweep with the clock stopped, rst/en wiggling.
    @(negedge clk);
    clk_run = 1'b0;
    for (int v = 0; v < 256; v++) begin
      in  = 8'(v);
      rst = v[0];
      en  = v[1];
      #1;
      check($sformatf("comb_%02h", v), out_c, valid_c, multi_c,
            ref_out(8'(v)), (v != 0), ($countones(8'(v)) >= 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/enc8x3.md
ENC8X3 -- requirements
Module: enc8x3

Interface
REQ-001 Parameter REG_OUT, default 1, meaning: 1 = outputs registered (one-cycle latency), 0 = outputs combinational from in.
REQ-002 clk  input  1  rising-edge clock for all registered state.
REQ-003 rst  input  1  reset, asynchronous and active-high; clears all registered state.
REQ-004 en  input  1  capture enable; when high at a rising clk edge, the encoded result of in is loaded.
REQ-005 in  input  8  request vector; bit 7 has highest priority, bit 0 lowest.
REQ-006 out  output  3  binary index of the highest-priority set bit of in.
REQ-007 valid  output  1  high when at least one bit of in was set.
REQ-008 multi  output  1  present only when ENC8X3_MULTI_EN is defined; high when two or more bits of in were set.

Function
REQ-009 Encode: out SHALL equal the index of the most-significant 1 in in; lower set bits are ignored.
REQ-010 Zero input: in = 8'h00 SHALL give out = 3'b000 and valid = 0.
REQ-011 Single-bit input 8'h01 SHALL give out = 3'b000 and valid = 1, distinguishing it from zero input only by valid.
REQ-012 REG_OUT = 1: out, valid (and multi) SHALL update at the rising clk edge where en = 1, from the in value sampled at that edge; latency exactly one cycle.
REQ-013 REG_OUT = 1, en = 0: outputs SHALL hold their last value regardless of in.
REQ-014 REG_OUT = 0: outputs SHALL be a purely combinational function of in; clk, en and rst have no effect.
REQ-015 Encoding logic SHALL be fully combinational and latch-free; every input pattern of the 256 SHALL resolve to a defined output.
REQ-016 No X propagation: with in fully driven, outputs SHALL never be X after reset release.

Reset
REQ-017 REG_OUT = 1: rst high SHALL immediately (without a clk edge) force out = 3'b000, valid = 0, multi = 0.
REQ-018 Outputs SHALL stay at reset values while rst is high, even with en = 1 and clk running.
REQ-019 After rst deasserts, the first rising clk edge with en = 1 SHALL load the encoded in normally.
REQ-020 Reset asserted mid-operation SHALL discard the held result; no prior value reappears after release.

Configuration
REQ-021 Macro ENC8X3_MULTI_EN: when defined, the multi port and its logic (popcount of in >= 2) SHALL be compiled in, registered and reset identically to valid; when undefined, the multi port SHALL not exist and out/valid behaviour SHALL be unchanged.

Verification
REQ-022 REG_OUT=1, rst pulse mid-cycle with out = 3'b111 -> out = 000, valid = 0 immediately, before any clk edge.
REQ-023 en=1, apply in = 00, 02, 07, 0A, 01, 0E, 1F, 40, 81 on successive cycles -> one cycle later out/valid = 000/0, 001/1, 010/1, 011/1, 000/1, 011/1, 100/1, 110/1, 111/1.
REQ-024 en=1 load in = 8'h40 (out 110), then en=0 and in = 8'h03 for 3 cycles -> out stays 110, valid stays 1.
REQ-025 REG_OUT=0, sweep all 256 in values -> outputs match reference priority model with zero clock edges.
REQ-026 ENC8X3_MULTI_EN defined: in = 8'h10 -> multi = 0; in = 8'h81 -> multi = 1; in = 8'h00 -> multi = 0, each one cycle after capture.
